axi4lite_wr_slave: RTL and testbench
====================================

// Module: axi4lite_wr_slave
// PURPOSE
//  AXI4-Lite write-only slave (responder). Accepts AW and W beats independently,
//  commits data with byte strobes into a NUM_REGS x DATA_WIDTH register bank and
//  returns a B response. Sits at the slave end of the write-only master's link;
//  rd_idx/rd_data expose register contents to downstream logic and the bench.
// PARAMETERS
//  ADDR_WIDTH  32            AWADDR width
//  DATA_WIDTH  32            WDATA width, multiple of 8
//  STRB_WIDTH  DATA_WIDTH/8  WSTRB width
//  NUM_REGS    8             number of registers, power of 2, >= 2
//  BASE_ADDR   0             byte address of register 0, STRB_WIDTH-aligned
// PORTS
//  pclk     in   1                  clock, rising edge
//  rst      in   1                  asynchronous reset, active-high
//  AWADDR   in   ADDR_WIDTH         write address
//  AWVALID  in   1                  address valid
//  AWREADY  out  1                  address ready
//  WDATA    in   DATA_WIDTH         write data
//  WSTRB    in   STRB_WIDTH         byte enables, bit i -> WDATA[8i+7:8i]
//  WVALID   in   1                  data valid
//  WREADY   out  1                  data ready
//  BRESP    out  2                  2'b00 OKAY, 2'b10 SLVERR
//  BVALID   out  1                  response valid
//  BREADY   in   1                  response ready
//  rd_idx   in   $clog2(NUM_REGS)   register select for the side read port
//  rd_data  out  DATA_WIDTH         regs[rd_idx], combinational
// BEHAVIOUR
//  Reset (async, while rst=1): registers=0, AW/W holding buffers empty, BVALID=0,
//   BRESP=2'b00, AWREADY=0, WREADY=0, state=IDLE. Reset mid-transaction discards
//   buffered AW/W and any pending response; no write completes afterwards.
//  FSM states:
//   IDLE:  AWREADY=~aw_full, WREADY=~w_full. A handshake (VALID&READY at an edge)
//          latches AWADDR or WDATA/WSTRB and sets aw_full or w_full. AW and W can
//          arrive in the same cycle or in either order, any gap. When both flags
//          are set after an edge -> WRITE.
//   WRITE: AWREADY=WREADY=0. One cycle: decode, apply strobes, load BRESP, set
//          BVALID, clear both flags -> RESP.
//   RESP:  AWREADY=WREADY=0. BVALID/BRESP held stable until BVALID&BREADY at an
//          edge, then BVALID=0 -> IDLE; readies rise in the following cycle.
//  Latency: AW and W handshakes at edge N -> register updated and BVALID=1 at
//   edge N+1. BREADY=1 throughout -> next AW/W accepted at edge N+3.
//  Decode: off = AWADDR - BASE_ADDR; idx = off >> $clog2(STRB_WIDTH); low bits
//   ignored. In range iff AWADDR >= BASE_ADDR and idx < NUM_REGS -> BRESP=OKAY,
//   regs[idx] byte i <= WDATA byte i where WSTRB[i]=1. Otherwise BRESP=SLVERR,
//   no register changes. WSTRB=0 in range -> OKAY, register unchanged.
//  Second beat on a full channel is not accepted (READY low); it is held by the
//   master until the current write completes.
//  rd_data reflects the write from edge N+1 combinationally after that edge.
// TESTING
//  1 AW+W same cycle, AWADDR=0x4, WDATA=0xDEADBEEF, WSTRB=4'hF, BREADY=1 ->
//    BVALID=1 one cycle later, BRESP=00; rd_idx=1 reads 0xDEADBEEF.
//  2 W (0x12345678) 3 cycles before AW (0x8) -> WREADY=0 after W capture,
//    AWREADY stays 1; write commits on AW arrival, regs[2]=0x12345678, OKAY.
//  3 regs[0]=0x11223344, then AWADDR=0x0, WDATA=0xAABBCCDD, WSTRB=4'b0101 ->
//    regs[0]=0x11BB33DD, BRESP=00.
//  4 AWADDR=0x20 (NUM_REGS=8, BASE_ADDR=0), WDATA=0xFFFFFFFF -> BRESP=2'b10,
//    all registers unchanged.
//  5 BREADY=0 for 5 cycles after BVALID -> BVALID/BRESP stable, AWREADY=WREADY=0,
//    new AWVALID/WVALID ignored; BREADY=1 -> BVALID=0, readies=1 one cycle later.
//  6 AW (0xC) captured, rst pulsed before W arrives -> BVALID=0, regs all 0,
//    later W alone produces no write and no response.

Source files
------------

// File: rtl/axi4lite_wr_slave.sv
// AXI4-Lite write-only slave: buffers AW and W beats independently, commits
// strobed data into a small register bank and answers with a B response.
module axi4lite_wr_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                        pclk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       AWADDR,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [DATA_WIDTH-1:0]       WDATA,
    input  logic [STRB_WIDTH-1:0]       WSTRB,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]       rd_data
);

    localparam int                    IDX_W     = $clog2(NUM_REGS);
    localparam int                    OFF_SHIFT = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] REG_LIMIT = ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RESP
    } state_t;

    state_t                               state;
    state_t                               next_state;
    logic                                 aw_full;
    logic                                 w_full;
    logic [ADDR_WIDTH-1:0]                aw_addr;
    logic [DATA_WIDTH-1:0]                w_data;
    logic [STRB_WIDTH-1:0]                w_strb;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
    logic                                 aw_hs;
    logic                                 w_hs;
    logic                                 off_borrow;
    logic [ADDR_WIDTH-1:0]                addr_off;
    logic [ADDR_WIDTH-1:0]                word_idx;
    logic                                 in_range;
    logic [IDX_W-1:0]                     reg_sel;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;

    // A borrow out of the offset subtraction means the address sits below the bank.
    assign {off_borrow, addr_off} = {1'b0, aw_addr} - {1'b0, BASE_ADDR};
    assign word_idx = addr_off >> OFF_SHIFT;
    assign in_range = ~off_borrow && (word_idx < REG_LIMIT);
    assign reg_sel  = word_idx[IDX_W-1:0];

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if ((aw_full | aw_hs) && (w_full | w_hs)) next_state = WRITE;
            WRITE:   next_state = RESP;
            RESP:    if (BVALID && BREADY) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        if (state == IDLE && !rst) begin
            AWREADY = ~aw_full;
            WREADY  = ~w_full;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else if (state == WRITE) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= AWADDR;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            BVALID <= 1'b0;
            BRESP  <= RESP_OKAY;
        end else if (state == WRITE) begin
            BVALID <= 1'b1;
            BRESP  <= in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (BVALID && BREADY) begin
            BVALID <= 1'b0;
        end
    end

    // Only strobed bytes of an in-range target change; everything else holds.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (state == WRITE && in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb[b]) begin
                    regs[reg_sel][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = regs[rd_idx];

endmodule

// File: tb/tb_axi4lite_wr_slave.sv
// Randomised and directed bench for axi4lite_wr_slave, checked against a
// byte-level register model held in the bench.
`timescale 1ns/1ps
module tb_axi4lite_wr_slave;

    logic        pclk = 1'b0;
    logic        rst;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data;

    logic [31:0] model [8];
    int          total  = 0;
    int          failed = 0;

    axi4lite_wr_slave dut (
        .pclk    (pclk),
        .rst     (rst),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always #50 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAllRegs(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            checkOutput($sformatf("%s_reg%0d", tag, i), rd_data, model[i]);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
    endtask

    // Register map: 8 words of 4 bytes starting at byte address 0.
    function automatic void modelWrite(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb, output logic [1:0] resp,
                                       output int idx);
        int unsigned word;
        word = addr / 4;
        idx  = int'(word);
        if (word < 8) begin
            resp = 2'b00;
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[word][8*b +: 8] = data[8*b +: 8];
        end else begin
            resp = 2'b10;
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int awDelay, input int wDelay,
                                 input int bDelay, input bit junk, input string tag);
        logic [1:0] expResp;
        int         idx;
        int         c;
        bit         awDone;
        bit         wDone;
        bit         awHs;
        bit         wHs;
        modelWrite(addr, data, strb, expResp, idx);
        c      = 0;
        awDone = 0;
        wDone  = 0;
        BREADY = 1'b0;
        while (!(awDone && wDone) && c < 50) begin
            AWADDR  = addr;
            WDATA   = data;
            WSTRB   = strb;
            AWVALID = !awDone && (c >= awDelay);
            WVALID  = !wDone && (c >= wDelay);
            #1;
            if (wDone && !awDone) begin
                checkOutput({tag, "_wready_held_low"}, 32'(WREADY), 32'd0);
                checkOutput({tag, "_awready_open"}, 32'(AWREADY), 32'd1);
            end
            awHs = AWVALID && AWREADY;
            wHs  = WVALID && WREADY;
            @(posedge pclk);
            @(negedge pclk);
            if (awHs) awDone = 1;
            if (wHs)  wDone  = 1;
            c++;
        end
        checkOutput({tag, "_handshakes_done"}, 32'(awDone && wDone), 32'd1);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        #1;
        checkOutput({tag, "_bvalid_before_commit"}, 32'(BVALID), 32'd0);
        checkOutput({tag, "_readies_low_in_write"}, 32'({AWREADY, WREADY}), 32'd0);
        @(posedge pclk);
        @(negedge pclk);
        for (int k = 0; k <= bDelay; k++) begin
            BREADY = (k == bDelay);
            if (junk && k < bDelay) begin
                AWVALID = 1'b1;
                AWADDR  = 32'h0;
                WVALID  = 1'b1;
                WDATA   = 32'hFFFF_FFFF;
                WSTRB   = 4'hF;
            end
            #1;
            checkOutput({tag, "_bvalid"}, 32'(BVALID), 32'd1);
            checkOutput({tag, "_bresp"}, 32'(BRESP), 32'(expResp));
            checkOutput({tag, "_readies_low_in_resp"}, 32'({AWREADY, WREADY}), 32'd0);
            if (k == 0 && expResp == 2'b00) begin
                rd_idx = 3'(idx);
                #1;
                checkOutput({tag, "_rd_data"}, rd_data, model[idx]);
            end
            @(posedge pclk);
            @(negedge pclk);
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        #1;
        checkOutput({tag, "_bvalid_cleared"}, 32'(BVALID), 32'd0);
        checkOutput({tag, "_readies_reopen"}, 32'({AWREADY, WREADY}), 32'd3);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        rst = 1'b0;
        clearModel();
    endtask

    initial begin
        rst     = 1'b1;
        AWADDR  = '0;
        AWVALID = 1'b0;
        WDATA   = '0;
        WSTRB   = '0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        rd_idx  = '0;
        clearModel();
        repeat (2) @(negedge pclk);
        #1;
        checkOutput("reset_awready", 32'(AWREADY), 32'd0);
        checkOutput("reset_wready", 32'(WREADY), 32'd0);
        checkOutput("reset_bvalid", 32'(BVALID), 32'd0);
        checkOutput("reset_bresp", 32'(BRESP), 32'd0);
        checkAllRegs("reset");
        @(negedge pclk);
        rst = 1'b0;
        #1;
        checkOutput("idle_readies", 32'({AWREADY, WREADY}), 32'd3);
        @(negedge pclk);

        applyStimulus(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, "t1_same_cycle");
        rd_idx = 3'd1;
        #1;
        checkOutput("t1_const", rd_data, 32'hDEAD_BEEF);

        applyStimulus(32'h8, 32'h1234_5678, 4'hF, 3, 0, 0, 0, "t2_w_first");
        rd_idx = 3'd2;
        #1;
        checkOutput("t2_const", rd_data, 32'h1234_5678);

        applyStimulus(32'h0, 32'h1122_3344, 4'hF, 0, 0, 0, 0, "t3_seed");
        applyStimulus(32'h0, 32'hAABB_CCDD, 4'b0101, 1, 0, 0, 0, "t3_strobe");
        rd_idx = 3'd0;
        #1;
        checkOutput("t3_const", rd_data, 32'h11BB_33DD);

        applyStimulus(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, "t4_out_of_range");
        checkAllRegs("t4_unchanged");

        applyStimulus(32'h10, 32'hCAFE_F00D, 4'hF, 0, 2, 5, 1, "t5_stall");
        checkAllRegs("t5_after_stall");

        applyStimulus(32'h1C, 32'h5555_AAAA, 4'h0, 0, 0, 0, 0, "zero_strobe");

        // Address captured alone, then reset wipes it before the data beat.
        AWADDR  = 32'hC;
        AWVALID = 1'b1;
        #1;
        checkOutput("t6_aw_ready", 32'(AWREADY), 32'd1);
        @(posedge pclk);
        @(negedge pclk);
        AWVALID = 1'b0;
        pulseReset();
        #1;
        checkOutput("t6_bvalid_after_reset", 32'(BVALID), 32'd0);
        checkAllRegs("t6_cleared");
        WDATA  = 32'h0BAD_0BAD;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        #1;
        checkOutput("t6_w_ready", 32'(WREADY), 32'd1);
        @(posedge pclk);
        @(negedge pclk);
        WVALID = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput("t6_no_response", 32'(BVALID), 32'd0);
            @(negedge pclk);
        end
        #1;
        checkOutput("t6_aw_still_open", 32'(AWREADY), 32'd1);
        checkOutput("t6_w_full", 32'(WREADY), 32'd0);
        checkAllRegs("t6_no_write");
        pulseReset();

        for (int n = 0; n < 40; n++) begin
            applyStimulus(32'($urandom_range(0, 44)), $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                          1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end
        checkAllRegs("final");

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
